// File: rtl/insloader_pkg.sv
// rtl/insloader_pkg.sv - shared state encoding and framing constants for the program loader
package insloader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDRBYTES  = 2;
    localparam int WORDBYTES = 4;

    // States in which the loader offers ready_out to the byte stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/wordassembler.sv
// rtl/wordassembler.sv - 8-to-32 big-endian shift register with byte counter
//
// Ports:
//   clk, clr   clock and synchronous active-high reset
//   clear      synchronous restart at the beginning of a frame
//   shift      a data byte is accepted this cycle
//   byte_in    stream byte
//   word       the 32-bit word formed by the held bytes plus byte_in
//   word_full  the byte accepted this cycle completes a word
module wordassembler
    import insloader_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (shift) begin
            shreg <= {shreg[15:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end

    // The word is presented together with its final byte so the loader can
    // register it on the same edge that accepts that byte.
    assign word      = {shreg, byte_in};
    assign word_full = shift && (cnt == 2'(WORDBYTES - 1));

endmodule

// File: rtl/insloader.sv
// rtl/insloader.sv - framed byte-stream loader for the instruction SRAM with checksum and core hold
//
// Ports:
//   clk, clr            clock and synchronous active-high reset
//   start               one-cycle pulse, begins a load from IDLE, DONE or ERR
//   byte_in, valid_in   stream byte and its valid
//   ready_out           loader can accept a byte (registered, state only)
//   mem_address         SRAM byte address
//   mem_din             SRAM write data
//   mem_wr, mem_cs      SRAM write strobe and chip select
//   cpuclr              core PC clear, active-low; high only in DONE
//   done, err           image loaded and verified / frame rejected
module insloader
    import insloader_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [AWIDTH-1:0] mem_address,
    output logic [DWIDTH-1:0] mem_din,
    output logic              mem_wr,
    output logic              mem_cs,
    output logic              cpuclr,
    output logic              done,
    output logic              err
);

    localparam int IW = $clog2(DEPTH + 1);

    state_t        state;
    state_t        nxt;
    logic [IW-1:0] index;
    logic [7:0]    sum;
    logic [15:0]   n_words;
    logic [15:0]   n_next;
    logic [31:0]   word;
    logic          word_full;
    logic          accept;
    logic          enter_hdr;

    assign accept    = valid_in && ready_out;
    assign enter_hdr = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    // Word count as it will be once the low header byte lands.
    assign n_next    = {n_words[15:8], byte_in};

    wordassembler u_wordassembler (
        .clk       (clk),
        .clr       (clr),
        .clear     (enter_hdr),
        .shift     (accept && (state == DATA)),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) nxt = HDR_HI;
            HDR_HI:          if (accept) nxt = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (n_next > 16'(DEPTH))  nxt = ERR;
                    else if (n_next == 16'd0) nxt = CHK;
                    else                      nxt = DATA;
                end
            end
            DATA:            if (word_full) nxt = WRITE;
            WRITE:           nxt = (16'(index) + 16'd1 == n_words) ? CHK : DATA;
            CHK:             if (accept) nxt = (byte_in == sum) ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with the
    // state it describes.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            ready_out   <= 1'b0;
            mem_wr      <= 1'b0;
            mem_cs      <= 1'b0;
            mem_address <= '0;
            mem_din     <= '0;
            cpuclr      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            index       <= '0;
            sum         <= '0;
            n_words     <= '0;
        end else begin
            state     <= nxt;
            ready_out <= accepts_bytes(nxt);
            mem_wr    <= (nxt == WRITE);
            mem_cs    <= (nxt == WRITE);
            cpuclr    <= (nxt == DONE);
            done      <= (nxt == DONE);
            err       <= (nxt == ERR);

            if (enter_hdr) begin
                index <= '0;
                sum   <= '0;
            end
            if (accept && (state == HDR_HI)) n_words[15:8] <= byte_in;
            if (accept && (state == HDR_LO)) n_words[7:0]  <= byte_in;
            if (accept && (state == DATA))   sum <= sum + byte_in;

            if (nxt == WRITE) begin
                mem_address <= AWIDTH'({index, 2'b00});
                mem_din     <= DWIDTH'(word);
            end
            if (state == WRITE) index <= index + IW'(1);
        end
    end

endmodule
